sys_arr_out_row_fifo: RTL

Parametrised output row buffer for the systolic array. Each of the N array columns pushes its result words independently, skewed in time, through its own shift strobe. The block deskews them into complete N-word rows, buffers up to DEPTH rows and presents them through a valid/ready handshake to the writeback path. It replaces the single-row, shift-only output FIFO with per-column write control, multi-row depth, backpressure and flush.

---
 rtl/sys_arr_out_row_fifo.sv | 108 ++++++++++
 1 files changed

// File: rtl/sys_arr_out_row_fifo.sv
// Systolic-array output row FIFO: per-column skewed pushes, shared row pop.
// Optional sticky drop flag enabled by defining SYS_ARR_OUT_FIFO_OVF_EN.
module sys_arr_out_row_fifo #(
    parameter int DW    = 16,
    parameter int N     = 4,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    shift,
    input  logic [DW*N-1:0] shift_value,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DW*N-1:0] out,
    output logic [PW-1:0]   row_count,
    output logic [N-1:0]    col_full,
    output logic            overflow
);

    localparam int AW = PW - 1;

    logic [DW-1:0] mem_q [DEPTH][N];
    logic [PW-1:0] wptr_q [N];
    logic [PW-1:0] wptr_d [N];
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rptr_d;
    logic [PW-1:0] occ [N];
    logic [N-1:0]  push;
    logic          pop;

    // A row is complete once every column holds it; min occupancy = rows.
    always_comb begin
        row_count = PW'(DEPTH);
        col_full  = '0;
        for (int c = 0; c < N; c++) begin
            occ[c]      = wptr_q[c] - rptr_q;
            col_full[c] = (occ[c] == PW'(DEPTH));
            if (occ[c] < row_count) begin
                row_count = occ[c];
            end
        end
    end

    assign out_valid = (row_count != '0);
    assign push      = shift & ~col_full & {N{~flush}};
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        for (int c = 0; c < N; c++) begin
            wptr_d[c] = flush ? '0 : wptr_q[c] + PW'(push[c]);
        end
        rptr_d = flush ? '0 : rptr_q + PW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                wptr_q[c] <= '0;
            end
            rptr_q <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                wptr_q[c] <= wptr_d[c];
            end
            rptr_q <= rptr_d;
        end
    end

    // Storage is intentionally not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (push[c]) begin
                mem_q[wptr_q[c][AW-1:0]][c] <= shift_value[DW*c +: DW];
            end
        end
    end

    always_comb begin
        out = '0;
        if (out_valid) begin
            for (int c = 0; c < N; c++) begin
                out[DW*c +: DW] = mem_q[rptr_q[AW-1:0]][c];
            end
        end
    end

`ifdef SYS_ARR_OUT_FIFO_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = flush ? 1'b0 : (ovf_q | (|(shift & col_full)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
